// File: rtl/instr_mem_loader_if.sv
//------------------------------------------------------------------------------
// Module : instr_mem_loader_if
// Purpose: Valid/ready program stream from the host-side source to the
//          instruction-memory loader.
// Signals: valid - data holds a stream word
//          data  - stream word (length, program words, optional checksum)
//          ready - loader accepts a word this cycle
// Modports: master (stream source), slave (loader)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface instr_mem_loader_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/instr_mem_loader.sv
//------------------------------------------------------------------------------
// Module : instr_mem_loader
// Purpose: Receives a length-prefixed program stream and writes it into the
//          instruction RAM at sequential addresses, holding the processor in
//          reset until the load completes.
// Ports  : clk, rst      - clock (rising edge), asynchronous active-high reset
//          i_start       - 1-cycle pulse, begin a new load
//          s_in          - stream slave (valid, data, ready)
//          o_wr_en/addr/data - instruction RAM write port
//          o_cpu_reset   - 1 = processor held in reset
//          o_done        - load complete, processor running
//          o_error       - load rejected, processor held in reset
//          o_word_count  - program words written in the current load
// Option : INSTR_LOADER_CHECKSUM_EN - expect a trailing modulo-2**16 sum word
//          after the program words; a mismatch rejects the load.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_mem_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_start,
  instr_mem_loader_if.slave      s_in,
  output logic                   o_wr_en,
  output logic [ADDR_W-1:0]      o_wr_addr,
  output logic [DATA_W-1:0]      o_wr_data,
  output logic                   o_cpu_reset,
  output logic                   o_done,
  output logic                   o_error,
  output logic [7:0]             o_word_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_LOAD    = 3'd2,
    S_CHECK   = 3'd3,
    S_RELEASE = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic [7:0]        r_len;
  logic [7:0]        r_word_count;
  logic              w_xfer;
  logic              w_last;
  logic              w_len_bad;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
`endif

  assign w_xfer    = s_in.valid & r_in_ready;
  // Word count doubles as the write index: transfer k sees count == k.
  assign w_last    = (r_word_count + 8'd1) == r_len;
  assign w_len_bad = (s_in.data == '0) || (s_in.data > DATA_W'(DEPTH));

  assign s_in.ready   = r_in_ready;
  assign o_word_count = r_word_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_len        <= '0;
      r_word_count <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_cpu_reset  <= 1'b1;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      o_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_RELEASE, S_ERR: begin
          if (i_start) begin
            r_state      <= S_LEN;
            r_in_ready   <= 1'b1;
            r_word_count <= '0;
            o_cpu_reset  <= 1'b1;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            if (w_len_bad) begin
              r_state    <= S_ERR;
              r_in_ready <= 1'b0;
              o_error    <= 1'b1;
            end else begin
              // Length is bounded by DEPTH here, so the low byte holds it.
              r_len   <= s_in.data[7:0];
              r_state <= S_LOAD;
`ifdef INSTR_LOADER_CHECKSUM_EN
              r_sum   <= '0;
`endif
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            o_wr_en      <= 1'b1;
            o_wr_addr    <= r_word_count[ADDR_W-1:0];
            o_wr_data    <= s_in.data;
            r_word_count <= r_word_count + 8'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_sum        <= r_sum + s_in.data;
            if (w_last) begin
              r_state <= S_CHECK;
            end
`else
            if (w_last) begin
              r_state     <= S_RELEASE;
              r_in_ready  <= 1'b0;
              o_cpu_reset <= 1'b0;
              o_done      <= 1'b1;
            end
`endif
          end
        end
        S_CHECK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (s_in.data == r_sum) begin
              r_state     <= S_RELEASE;
              o_cpu_reset <= 1'b0;
              o_done      <= 1'b1;
            end else begin
              r_state <= S_ERR;
              o_error <= 1'b1;
            end
          end
`else
          // Unreachable without the checksum word; recover to a safe state.
          r_state    <= S_ERR;
          r_in_ready <= 1'b0;
          o_error    <= 1'b1;
`endif
        end
        default: begin
          r_state    <= S_ERR;
          r_in_ready <= 1'b0;
          o_error    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
//------------------------------------------------------------------------------
// Module : tb_instr_mem_loader
// Purpose: Self-checking bench for instr_mem_loader: a table of streams plus
//          hand-written sequences for gapped full-depth loads, reset mid-load
//          and (when INSTR_LOADER_CHECKSUM_EN is defined) checksum handling.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_mem_loader;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        o_wr_en;
  logic [6:0]  o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_cpu_reset;
  logic        o_done;
  logic        o_error;
  logic [7:0]  o_word_count;

  instr_mem_loader_if #(.DATA_W(16)) s_if ();

  instr_mem_loader #(.ADDR_W(7), .DATA_W(16), .DEPTH(128)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .s_in         (s_if.slave),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_cpu_reset  (o_cpu_reset),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Every RAM write observed, one entry per cycle of o_wr_en.
  logic [6:0]  log_addr [$];
  logic [15:0] log_data [$];

  always @(negedge clk) begin
    if (o_wr_en) begin
      log_addr.push_back(o_wr_addr);
      log_data.push_back(o_wr_data);
    end
  end

  typedef struct {
    int          nw;        // stream words excluding any checksum
    logic [15:0] w [5];
    int          exp_cnt;
    bit          exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Offer one word; returns ok=1 once it was accepted. Leaves time at edge+1.
  task automatic send(input logic [15:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    s_if.valid = 1'b1;
    s_if.data  = d;
    for (int t = 0; t < 20; t++) begin
      if (s_if.ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    s_if.valid = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    bit          ok;
    logic [15:0] sum;
    vec_t        v;
    v   = vecs[idx];
    sum = '0;
    pulse_start();
    log_addr.delete();
    log_data.delete();
    send(v.w[0], ok);
    chk($sformatf("v%0d len_xfer", idx), 32'(ok), 32'd1);
    for (int k = 1; k < v.nw; k++) begin
      send(v.w[k], ok);
      sum = sum + v.w[k];
      chk($sformatf("v%0d xfer%0d", idx, k), 32'(ok), 32'd1);
      chk($sformatf("v%0d wr_en%0d", idx, k), 32'(o_wr_en), 32'd1);
      chk($sformatf("v%0d wr_addr%0d", idx, k), 32'(o_wr_addr), 32'(k - 1));
      chk($sformatf("v%0d wr_data%0d", idx, k), 32'(o_wr_data), 32'(v.w[k]));
      chk($sformatf("v%0d count%0d", idx, k), 32'(o_word_count), 32'(k));
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (v.exp_done) begin
      send(sum, ok);
      chk($sformatf("v%0d csum_xfer", idx), 32'(ok), 32'd1);
    end
`endif
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d done", idx), 32'(o_done), 32'(v.exp_done));
    chk($sformatf("v%0d error", idx), 32'(o_error), 32'(!v.exp_done));
    chk($sformatf("v%0d cpu_reset", idx), 32'(o_cpu_reset), 32'(!v.exp_done));
    chk($sformatf("v%0d in_ready", idx), 32'(s_if.ready), 32'd0);
    chk($sformatf("v%0d word_count", idx), 32'(o_word_count), 32'(v.exp_cnt));
    chk($sformatf("v%0d n_writes", idx), 32'(log_addr.size()), 32'(v.exp_cnt));
    for (int k = 0; k < log_addr.size() && k < v.exp_cnt; k++) begin
      chk($sformatf("v%0d log_addr%0d", idx, k), 32'(log_addr[k]), 32'(k));
      chk($sformatf("v%0d log_data%0d", idx, k), 32'(log_data[k]), 32'(v.w[k + 1]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [15:0] sum;
    logic [15:0] wd;

    vecs[0].nw = 4; vecs[0].w = '{16'd3, 16'h1111, 16'h2222, 16'h3333, 16'h0};
    vecs[0].exp_cnt = 3; vecs[0].exp_done = 1'b1;
    vecs[1].nw = 1; vecs[1].w = '{16'd0, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[1].exp_cnt = 0; vecs[1].exp_done = 1'b0;
    vecs[2].nw = 2; vecs[2].w = '{16'd1, 16'hABCD, 16'h0, 16'h0, 16'h0};
    vecs[2].exp_cnt = 1; vecs[2].exp_done = 1'b1;
    vecs[3].nw = 1; vecs[3].w = '{16'd129, 16'h0, 16'h0, 16'h0, 16'h0};
    vecs[3].exp_cnt = 0; vecs[3].exp_done = 1'b0;
    vecs[4].nw = 5; vecs[4].w = '{16'd4, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
    vecs[4].exp_cnt = 4; vecs[4].exp_done = 1'b1;
    vecs[5].nw = 3; vecs[5].w = '{16'd2, 16'h0F0F, 16'hF0F0, 16'h0, 16'h0};
    vecs[5].exp_cnt = 2; vecs[5].exp_done = 1'b1;

    rst        = 1'b1;
    i_start    = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(s_if.ready), 32'd0);
    chk("rst wr_en", 32'(o_wr_en), 32'd0);
    chk("rst wr_addr", 32'(o_wr_addr), 32'd0);
    chk("rst wr_data", 32'(o_wr_data), 32'd0);
    chk("rst cpu_reset", 32'(o_cpu_reset), 32'd1);
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst error", 32'(o_error), 32'd0);
    chk("rst word_count", 32'(o_word_count), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle in_ready", 32'(s_if.ready), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Full-depth load with a one-cycle gap between every word.
    pulse_start();
    log_addr.delete();
    log_data.delete();
    sum = '0;
    send(16'd128, ok);
    chk("d128 len_xfer", 32'(ok), 32'd1);
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      wd  = 16'(k * 3 + 7);
      sum = sum + wd;
      send(wd, ok);
      if (!ok || o_wr_addr != 7'(k) || o_wr_data != wd || !o_wr_en)
        chk($sformatf("d128 word%0d", k), {o_wr_en, 8'(o_wr_addr), wd}, {1'b1, 8'(k), wd});
    end
    n_checks++;
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(sum, ok);
    chk("d128 csum_xfer", 32'(ok), 32'd1);
`endif
    repeat (2) @(negedge clk);
    chk("d128 n_writes", 32'(log_addr.size()), 32'd128);
    chk("d128 last_addr", 32'(log_addr[127]), 32'd127);
    chk("d128 word_count", 32'(o_word_count), 32'd128);
    chk("d128 done", 32'(o_done), 32'd1);
    chk("d128 cpu_reset", 32'(o_cpu_reset), 32'd0);

    // Reset after 2 of 4 words, with an ignored Start in between.
    pulse_start();
    chk("rs start_cpu_reset", 32'(o_cpu_reset), 32'd1);
    chk("rs start_done", 32'(o_done), 32'd0);
    send(16'd4, ok);
    send(16'hAAAA, ok);
    send(16'hBBBB, ok);
    chk("rs mid_count", 32'(o_word_count), 32'd2);
    pulse_start();
    chk("rs start_ignored_count", 32'(o_word_count), 32'd2);
    chk("rs start_ignored_ready", 32'(s_if.ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs in_ready", 32'(s_if.ready), 32'd0);
    chk("rs cpu_reset", 32'(o_cpu_reset), 32'd1);
    chk("rs word_count", 32'(o_word_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vecs[0].nw = 5; vecs[0].w = '{16'd4, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    vecs[0].exp_cnt = 4; vecs[0].exp_done = 1'b1;
    run_vec(0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    pulse_start();
    send(16'd2, ok);
    send(16'hFFFF, ok);
    send(16'h0002, ok);
    send(16'h0001, ok);
    repeat (2) @(negedge clk);
    chk("cs good done", 32'(o_done), 32'd1);
    chk("cs good error", 32'(o_error), 32'd0);
    pulse_start();
    send(16'd2, ok);
    send(16'hFFFF, ok);
    send(16'h0002, ok);
    send(16'h0002, ok);
    repeat (2) @(negedge clk);
    chk("cs bad error", 32'(o_error), 32'd1);
    chk("cs bad cpu_reset", 32'(o_cpu_reset), 32'd1);
    chk("cs bad done", 32'(o_done), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
